// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back stage.
// Covers the late-return queue entry, the parameter defaults and the regfile port select.
package wb_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned CSRAW_DEF = 12;
  localparam int unsigned RIW_DEF   = $clog2(NREG_DEF);

  typedef struct packed {
    logic [RIW_DEF-1:0]  idx;
    logic [XLEN_DEF-1:0] data;
  } retq_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_PIPE  = 2'd1,
    SEL_QUEUE = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/wb_retq.sv
// Late load-return FIFO: a power-of-two ring buffer with an occupancy count and a
// combinational head peek.
module wb_retq
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter type         entry_t = retq_entry_t
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_push,
  input  entry_t                     i_din,
  input  logic                       i_pop,
  output entry_t                     o_head_c,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full_c,
  output logic                       o_empty_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;
  assign o_head_c  = r_mem[r_rptr];
  assign w_push    = i_push && !o_full_c;
  assign w_pop     = i_pop && !o_empty_c;

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: arbitrates in-order pipeline writes against queued late load
// returns on the single regfile port, suppresses writes on traps, tracks pending rds.
module wb_unit
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CSRAW = CSRAW_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     mem2wb_valid,
  input  logic                     mem2wb_wr_reg,
  input  logic [$clog2(NREG)-1:0]  mem2wb_wr_regindex,
  input  logic [XLEN-1:0]          mem2wb_wr_wdata,
  input  logic                     mem2wb_wr_csrreg,
  input  logic [CSRAW-1:0]         mem2wb_wr_csrindex,
  input  logic [XLEN-1:0]          mem2wb_wr_csrwdata,
  input  logic                     mem2wb_exp,
  input  logic                     mem2wb_int,
  input  logic                     lsu2wb_valid,
  input  logic [$clog2(NREG)-1:0]  lsu2wb_regindex,
  input  logic [XLEN-1:0]          lsu2wb_rdata,
  output logic                     wb2lsu_ready,
  output logic                     wb_stall,
  output logic                     wb2regfile_wr_reg,
  output logic [$clog2(NREG)-1:0]  wb2regfile_wr_regindex,
  output logic [XLEN-1:0]          wb2regfile_wr_wdata,
  output logic                     wb2csrfile_wr_reg,
  output logic [CSRAW-1:0]         wb2csrfile_wr_regindex,
  output logic [XLEN-1:0]          wb2csrfile_wr_wdata,
  output logic                     wb2csrfile_trap,
  output logic [NREG-1:0]          wb_pending_mask,
  output logic                     wb_err
);

  localparam int unsigned RIW = $clog2(NREG);
  localparam int unsigned CW  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [RIW-1:0]  idx;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          w_din;
  entry_t          w_head;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_trap;
  logic            w_pipe_rd;
  logic            w_stall;
  logic            w_retire;
  logic            w_err_evt;
  wb_sel_e         w_sel;
  logic [NREG-1:0] w_mask_nxt;

  logic            r_rf_we;
  logic [RIW-1:0]  r_rf_idx;
  logic [XLEN-1:0] r_rf_data;
  logic            r_csr_we;
  logic [CSRAW-1:0] r_csr_idx;
  logic [XLEN-1:0] r_csr_data;
  logic            r_trap;
  logic [NREG-1:0] r_mask;
  logic            r_err;

  assign w_din.idx  = lsu2wb_regindex;
  assign w_din.data = lsu2wb_rdata;
  // Index-0 returns are accepted but dropped; x0 can never be pending.
  assign w_push     = lsu2wb_valid && wb2lsu_ready && (lsu2wb_regindex != '0);
  assign w_pop      = (w_sel == SEL_QUEUE);

  wb_retq #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_retq (
    .clk       (clk),
    .rstn      (rstn),
    .i_push    (w_push),
    .i_din     (w_din),
    .i_pop     (w_pop),
    .o_head_c  (w_head),
    .o_count   (w_count),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  assign wb2lsu_ready = (w_count != CW'(DEPTH));
  assign wb_stall     = w_stall;

  // Port arbitration: a full queue beats the pipeline, otherwise the pipeline wins.
  always_comb begin
    w_trap    = mem2wb_exp | mem2wb_int;
    w_pipe_rd = mem2wb_valid && mem2wb_wr_reg && !w_trap && (mem2wb_wr_regindex != '0);
    w_stall   = w_pipe_rd && w_full;
    w_retire  = mem2wb_valid && !w_stall;
    w_sel     = SEL_NONE;
    if (w_stall)        w_sel = SEL_QUEUE;
    else if (w_pipe_rd) w_sel = SEL_PIPE;
    else if (!w_empty)  w_sel = SEL_QUEUE;
    w_err_evt = (w_pipe_rd && r_mask[mem2wb_wr_regindex]) ||
                (lsu2wb_valid && !wb2lsu_ready);
  end

  // Set after clear so a same-register refill stays pending.
  always_comb begin
    w_mask_nxt = r_mask;
    if (w_pop)  w_mask_nxt[w_head.idx] = 1'b0;
    if (w_push) w_mask_nxt[lsu2wb_regindex] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rf_we    <= 1'b0;
      r_rf_idx   <= '0;
      r_rf_data  <= '0;
      r_csr_we   <= 1'b0;
      r_csr_idx  <= '0;
      r_csr_data <= '0;
      r_trap     <= 1'b0;
      r_mask     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_mask <= w_mask_nxt;
      r_err  <= r_err | w_err_evt;
      r_trap <= w_retire && w_trap;
      case (w_sel)
        SEL_PIPE: begin
          r_rf_we   <= 1'b1;
          r_rf_idx  <= mem2wb_wr_regindex;
          r_rf_data <= mem2wb_wr_wdata;
        end
        SEL_QUEUE: begin
          r_rf_we   <= 1'b1;
          r_rf_idx  <= w_head.idx;
          r_rf_data <= w_head.data;
        end
        default: begin
          r_rf_we   <= 1'b0;
          r_rf_idx  <= '0;
          r_rf_data <= '0;
        end
      endcase
      if (w_retire && mem2wb_wr_csrreg && !w_trap) begin
        r_csr_we   <= 1'b1;
        r_csr_idx  <= mem2wb_wr_csrindex;
        r_csr_data <= mem2wb_wr_csrwdata;
      end else begin
        r_csr_we   <= 1'b0;
        r_csr_idx  <= '0;
        r_csr_data <= '0;
      end
    end
  end

  assign wb2regfile_wr_reg      = r_rf_we;
  assign wb2regfile_wr_regindex = r_rf_idx;
  assign wb2regfile_wr_wdata    = r_rf_data;
  assign wb2csrfile_wr_reg      = r_csr_we;
  assign wb2csrfile_wr_regindex = r_csr_idx;
  assign wb2csrfile_wr_wdata    = r_csr_data;
  assign wb2csrfile_trap        = r_trap;
  assign wb_pending_mask        = r_mask;
  assign wb_err                 = r_err;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: pipeline writes, traps, late returns, queue-full
// arbitration, x0 handling, mid-operation reset and the sticky error flag.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem2wb_valid, mem2wb_wr_reg, mem2wb_wr_csrreg, mem2wb_exp, mem2wb_int;
  logic [4:0]  mem2wb_wr_regindex;
  logic [31:0] mem2wb_wr_wdata, mem2wb_wr_csrwdata;
  logic [11:0] mem2wb_wr_csrindex;
  logic        lsu2wb_valid;
  logic [4:0]  lsu2wb_regindex;
  logic [31:0] lsu2wb_rdata;
  logic        wb2lsu_ready, wb_stall;
  logic        wb2regfile_wr_reg;
  logic [4:0]  wb2regfile_wr_regindex;
  logic [31:0] wb2regfile_wr_wdata;
  logic        wb2csrfile_wr_reg;
  logic [11:0] wb2csrfile_wr_regindex;
  logic [31:0] wb2csrfile_wr_wdata;
  logic        wb2csrfile_trap;
  logic [31:0] wb_pending_mask;
  logic        wb_err;

  int n_checks = 0;
  int n_err    = 0;

  wb_unit dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .mem2wb_valid           (mem2wb_valid),
    .mem2wb_wr_reg          (mem2wb_wr_reg),
    .mem2wb_wr_regindex     (mem2wb_wr_regindex),
    .mem2wb_wr_wdata        (mem2wb_wr_wdata),
    .mem2wb_wr_csrreg       (mem2wb_wr_csrreg),
    .mem2wb_wr_csrindex     (mem2wb_wr_csrindex),
    .mem2wb_wr_csrwdata     (mem2wb_wr_csrwdata),
    .mem2wb_exp             (mem2wb_exp),
    .mem2wb_int             (mem2wb_int),
    .lsu2wb_valid           (lsu2wb_valid),
    .lsu2wb_regindex        (lsu2wb_regindex),
    .lsu2wb_rdata           (lsu2wb_rdata),
    .wb2lsu_ready           (wb2lsu_ready),
    .wb_stall               (wb_stall),
    .wb2regfile_wr_reg      (wb2regfile_wr_reg),
    .wb2regfile_wr_regindex (wb2regfile_wr_regindex),
    .wb2regfile_wr_wdata    (wb2regfile_wr_wdata),
    .wb2csrfile_wr_reg      (wb2csrfile_wr_reg),
    .wb2csrfile_wr_regindex (wb2csrfile_wr_regindex),
    .wb2csrfile_wr_wdata    (wb2csrfile_wr_wdata),
    .wb2csrfile_trap        (wb2csrfile_trap),
    .wb_pending_mask        (wb_pending_mask),
    .wb_err                 (wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem2wb_valid = 0; mem2wb_wr_reg = 0; mem2wb_wr_regindex = '0; mem2wb_wr_wdata = '0;
    mem2wb_wr_csrreg = 0; mem2wb_wr_csrindex = '0; mem2wb_wr_csrwdata = '0;
    mem2wb_exp = 0; mem2wb_int = 0;
    lsu2wb_valid = 0; lsu2wb_regindex = '0; lsu2wb_rdata = '0;
  endtask

  task automatic pipe(input logic [4:0] idx, input logic [31:0] data);
    mem2wb_valid = 1; mem2wb_wr_reg = 1; mem2wb_wr_regindex = idx; mem2wb_wr_wdata = data;
  endtask

  task automatic lsu(input logic [4:0] idx, input logic [31:0] data);
    lsu2wb_valid = 1; lsu2wb_regindex = idx; lsu2wb_rdata = data;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] idx,
                        input logic [31:0] data);
    chk({tag, ".we"}, wb2regfile_wr_reg, we);
    if (we) begin
      chk({tag, ".idx"}, wb2regfile_wr_regindex, idx);
      chk({tag, ".data"}, wb2regfile_wr_wdata, data);
    end
  endtask

  initial begin
    idle();
    rstn = 0;
    #3;
    chk("rst.rf_we", wb2regfile_wr_reg, 0);
    chk("rst.csr_we", wb2csrfile_wr_reg, 0);
    chk("rst.trap", wb2csrfile_trap, 0);
    chk("rst.mask", wb_pending_mask, 0);
    chk("rst.err", wb_err, 0);
    chk("rst.ready", wb2lsu_ready, 1);
    chk("rst.stall", wb_stall, 0);
    rstn = 1;
    step();

    // plain pipeline write
    pipe(5'd5, 32'h1234);
    chk("p5.stall", wb_stall, 0);
    step();
    idle();
    chk_rf("p5", 1, 5'd5, 32'h1234);
    step();
    chk_rf("p5.once", 0, '0, '0);

    // trapping instruction with rd and CSR writes
    pipe(5'd6, 32'h6666);
    mem2wb_wr_csrreg = 1; mem2wb_wr_csrindex = 12'h300; mem2wb_wr_csrwdata = 32'hBEEF;
    mem2wb_exp = 1;
    step();
    idle();
    chk_rf("trap.rf", 0, '0, '0);
    chk("trap.csr_we", wb2csrfile_wr_reg, 0);
    chk("trap.pulse", wb2csrfile_trap, 1);
    step();
    chk("trap.pulse_end", wb2csrfile_trap, 0);

    // non-trapping CSR write
    mem2wb_valid = 1; mem2wb_wr_csrreg = 1;
    mem2wb_wr_csrindex = 12'h341; mem2wb_wr_csrwdata = 32'hDEAD_0001;
    step();
    idle();
    chk("csr.we", wb2csrfile_wr_reg, 1);
    chk("csr.idx", wb2csrfile_wr_regindex, 12'h341);
    chk("csr.data", wb2csrfile_wr_wdata, 32'hDEAD_0001);
    step();

    // single late return, pipeline idle
    lsu(5'd7, 32'hA5A5);
    step();
    idle();
    chk("lsu7.mask", wb_pending_mask, 32'h80);
    chk_rf("lsu7.t1", 0, '0, '0);
    step();
    chk_rf("lsu7.t2", 1, 5'd7, 32'hA5A5);
    chk("lsu7.mask_clr", wb_pending_mask, 0);
    step();

    // fill queue while the pipeline owns the port
    for (int k = 1; k <= 4; k++) begin
      lsu(5'(k), 32'h1000 + 32'(k));
      pipe(5'(9 + k), 32'h9000 + 32'(k));
      chk("fill.ready", wb2lsu_ready, 1);
      chk("fill.stall", wb_stall, 0);
      step();
      chk_rf("fill.rf", 1, 5'(9 + k), 32'h9000 + 32'(k));
    end
    idle();
    chk("full.mask", wb_pending_mask, 32'h1E);
    chk("full.ready", wb2lsu_ready, 0);
    pipe(5'd20, 32'h2020);
    chk("full.stall", wb_stall, 1);
    step();
    chk_rf("full.head", 1, 5'd1, 32'h1001);
    chk("full.mask1", wb_pending_mask, 32'h1C);
    chk("full.unstall", wb_stall, 0);
    step();
    idle();
    chk_rf("full.pipe", 1, 5'd20, 32'h2020);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk_rf("drain", 1, 5'(k), 32'h1000 + 32'(k));
    end
    chk("drain.mask", wb_pending_mask, 0);
    step();
    chk_rf("drain.done", 0, '0, '0);

    // x0 handling
    lsu(5'd0, 32'hFFFF);
    step();
    idle();
    chk("x0.mask", wb_pending_mask, 0);
    chk("x0.ready", wb2lsu_ready, 1);
    pipe(5'd0, 32'h5555);
    step();
    idle();
    chk_rf("x0.lsu", 0, '0, '0);
    step();
    chk_rf("x0.pipe", 0, '0, '0);

    // reset with three entries queued
    for (int k = 1; k <= 3; k++) begin
      lsu(5'(k), 32'h7000 + 32'(k));
      pipe(5'(9 + k), 32'h8000 + 32'(k));
      step();
    end
    chk("q3.mask", wb_pending_mask, 32'h0E);
    idle();
    #2 rstn = 0;
    #1;
    chk("mrst.mask", wb_pending_mask, 0);
    chk_rf("mrst.rf", 0, '0, '0);
    chk("mrst.ready", wb2lsu_ready, 1);
    #2 rstn = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_rf("mrst.nowr", 0, '0, '0);
    end

    // pipeline write to a pending register
    lsu(5'd3, 32'h3333);
    pipe(5'd10, 32'hAAAA);
    step();
    idle();
    chk("err.mask", wb_pending_mask, 32'h8);
    chk("err.pre", wb_err, 0);
    pipe(5'd3, 32'hBBBB);
    step();
    idle();
    chk("err.set", wb_err, 1);
    chk_rf("err.pipe", 1, 5'd3, 32'hBBBB);
    step();
    chk_rf("err.ovr", 1, 5'd3, 32'h3333);
    step();
    step();
    chk("err.sticky", wb_err, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
# wb_unit

Parametrised write-back stage that sits between the mem2wb pipeline register and the regfile/csrfile. It also accepts out-of-order late load returns from the LSU into a DEPTH-entry queue and arbitrates them against in-order pipeline writes onto the single regfile write port. It suppresses regfile/CSR writes for trapping instructions and exports a pending-register scoreboard to decode. All regfile and CSR outputs are registered.

## Interface
- XLEN, 32, data width of regfile/CSR write data
- NREG, 32, number of architectural registers; RIW = $clog2(NREG)
- DEPTH, 4, late-return queue entries (power of two, ≥2)
- CSRAW, 12, CSR index width

- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- mem2wb_valid  in  1  pipeline stage holds an instruction
- mem2wb_wr_reg  in  1  instruction writes rd
- mem2wb_wr_regindex  in  RIW  rd index
- mem2wb_wr_wdata  in  XLEN  rd data
- mem2wb_wr_csrreg  in  1  instruction writes a CSR
- mem2wb_wr_csrindex  in  CSRAW  CSR index
- mem2wb_wr_csrwdata  in  XLEN  CSR data
- mem2wb_exp  in  1  instruction raised an exception
- mem2wb_int  in  1  interrupt taken on this instruction
- lsu2wb_valid  in  1  late load return valid
- lsu2wb_regindex  in  RIW  destination register
- lsu2wb_rdata  in  XLEN  load data
- wb2lsu_ready  out  1  queue can accept (count < DEPTH)
- wb_stall  out  1  pipeline instruction not retired this cycle; mem2wb must hold
- wb2regfile_wr_reg  out  1  regfile write enable (registered)
- wb2regfile_wr_regindex  out  RIW  regfile write index (registered)
- wb2regfile_wr_wdata  out  XLEN  regfile write data (registered)
- wb2csrfile_wr_reg  out  1  CSR write enable (registered)
- wb2csrfile_wr_regindex  out  CSRAW  CSR index (registered)
- wb2csrfile_wr_wdata  out  XLEN  CSR data (registered)
- wb2csrfile_trap  out  1  one-cycle pulse, trap retired (registered)
- wb_pending_mask  out  NREG  bit r set while a queue entry targets register r
- wb_err  out  1  sticky protocol-violation flag

## Operation
- A pipeline instruction retires when mem2wb_valid && !wb_stall.
- Trap: on a retiring instruction with mem2wb_exp|mem2wb_int, both regfile and CSR writes are suppressed and wb2csrfile_trap is pulsed. Queue contents are unaffected; loads already returned still commit.
- Enqueue happens when lsu2wb_valid && wb2lsu_ready: index and data go to the tail, and mask[index] is set. An index-0 return is accepted and discarded (no enqueue).
- Regfile port arbitration, per cycle:
  - Queue full (count == DEPTH) with a pipeline rd write pending: the queue head wins and wb_stall = 1.
  - Otherwise the pipeline rd write wins, and the head waits.
  - Pipeline has no rd write (invalid, no wr_reg, trapping, or rd = 0): the head drains.
- Dequeue clears mask[head index].
- CSR writes never contend with the queue. They are never stalled except by wb_stall on the same instruction.
- Writes to x0 are never issued: wr_reg is forced to 0.
- Enqueue and dequeue in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- wb_err is set, and held until reset, on either violation:
  - a pipeline rd write whose index has its mask bit set;
  - lsu2wb_valid while wb2lsu_ready = 0.
- Decode must stall on wb_pending_mask, so the first violation never occurs legally.
- Behaviour on a violation: the pipeline write still issues, and the queue entry later overwrites it.

## Timing
- A write selected in cycle t appears on wb2regfile_*/wb2csrfile_* in cycle t+1, for exactly one cycle.
- Minimum enqueue-to-regfile latency is 2 cycles (enqueue at t, drain at t+1, visible at t+2).
- wb_pending_mask and wb2lsu_ready are derived from state registers and reflect updates from the previous edge.
- wb_stall is combinational from count and the mem2wb_* inputs.
- Reset values: all registered outputs 0, count 0, pointers 0, mask all-0, wb_err 0. wb2lsu_ready = 1 and wb_stall = 0 during and after reset.
- Reset mid-operation discards all queued loads with no write issued.

## Structure
- Shared package wb_pkg holds the queue entry struct {RIW idx; XLEN data}, the default parameter constants, and the arbitration select encoding (SEL_NONE, SEL_PIPE, SEL_QUEUE).
- One sub-module, wb_retq: a parametrised FIFO with count, full/empty, and a head peek.
- The mask update, arbitration and output registers live in wb_unit.

## Test plan
- Pipeline write x5 = 0x1234 with no queue activity → next cycle wr_reg = 1, idx 5, data 0x1234; wb_stall = 0.
- mem2wb_exp = 1 with wr_reg = 1 and wr_csrreg = 1 → no regfile/CSR write; trap pulses high for exactly 1 cycle.
- LSU returns x7 = 0xA5A5 while the pipeline is idle → mask[7] = 1 next cycle; regfile write x7 at t+2; mask[7] clears.
- Fill the queue with x1..x4 while the pipeline writes every cycle → wb2lsu_ready = 0. The next pipeline write sees wb_stall = 1 while the head x1 drains. The pipeline then retires, and entries drain in x1..x4 order.
- LSU return with index 0 → no enqueue, no write, mask unchanged; rd = 0 pipeline write → wr_reg stays 0.
- Assert rstn low with 3 entries queued → count 0, mask 0, outputs 0 immediately; no writes after release. Pipeline write to x3 while mask[3] = 1 → wb_err rises and stays high.
